// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative restoring radix-2 divide/remainder unit for the
//               RV64M DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW operations.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int DATA_WIDTH    = 64,
    parameter int WORD_WIDTH    = 32,
    parameter int CONTROL_WIDTH = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [CONTROL_WIDTH-1:0] div_control_i,
    input  logic [DATA_WIDTH-1:0]    src_1_i,
    input  logic [DATA_WIDTH-1:0]    src_2_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [DATA_WIDTH-1:0]    div_result_o,
    output logic                     busy_o
);

    localparam logic [CONTROL_WIDTH-1:0] c_OP_DIV   = 5'b10011;
    localparam logic [CONTROL_WIDTH-1:0] c_OP_DIVU  = 5'b10100;
    localparam logic [CONTROL_WIDTH-1:0] c_OP_REM   = 5'b10101;
    localparam logic [CONTROL_WIDTH-1:0] c_OP_REMU  = 5'b10110;
    localparam logic [CONTROL_WIDTH-1:0] c_OP_DIVW  = 5'b11000;
    localparam logic [CONTROL_WIDTH-1:0] c_OP_DIVUW = 5'b11001;
    localparam logic [CONTROL_WIDTH-1:0] c_OP_REMW  = 5'b11010;
    localparam logic [CONTROL_WIDTH-1:0] c_OP_REMUW = 5'b11011;
    localparam int                       c_CNT_W    = $clog2(DATA_WIDTH) + 1;
    localparam int                       c_PAD_W    = DATA_WIDTH - WORD_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_req_ready;
    logic                    r_resp_valid;
    logic                    r_busy;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_is_w;
    logic                    r_is_rem;
    logic                    r_neg_q;
    logic                    r_neg_r;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0]   r_quot;
    logic [DATA_WIDTH-1:0]   r_rem;
    logic [DATA_WIDTH-1:0]   r_divisor;

    logic                    w_known;
    logic                    w_is_w;
    logic                    w_signed;
    logic                    w_is_rem;

    always_comb begin
        w_known  = 1'b1;
        w_is_w   = 1'b0;
        w_signed = 1'b0;
        w_is_rem = 1'b0;
        case (div_control_i)
            c_OP_DIV:   w_signed = 1'b1;
            c_OP_DIVU:  ;
            c_OP_REM:   begin w_signed = 1'b1; w_is_rem = 1'b1; end
            c_OP_REMU:  w_is_rem = 1'b1;
            c_OP_DIVW:  begin w_is_w = 1'b1; w_signed = 1'b1; end
            c_OP_DIVUW: w_is_w = 1'b1;
            c_OP_REMW:  begin w_is_w = 1'b1; w_signed = 1'b1; w_is_rem = 1'b1; end
            c_OP_REMUW: begin w_is_w = 1'b1; w_is_rem = 1'b1; end
            default:    w_known = 1'b0;
        endcase
    end

    // W operands are re-expressed as 64-bit values so one datapath serves both widths
    logic [DATA_WIDTH-1:0] w_a_sx;
    logic [DATA_WIDTH-1:0] w_b_sx;
    logic [DATA_WIDTH-1:0] w_a_ext;
    logic [DATA_WIDTH-1:0] w_b_ext;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_WIDTH-1:0] w_a_mag;
    logic [DATA_WIDTH-1:0] w_b_mag;
    logic [DATA_WIDTH-1:0] w_min;
    logic                  w_div_zero;
    logic                  w_overflow;

    assign w_a_sx     = {{c_PAD_W{src_1_i[WORD_WIDTH-1]}}, src_1_i[WORD_WIDTH-1:0]};
    assign w_b_sx     = {{c_PAD_W{src_2_i[WORD_WIDTH-1]}}, src_2_i[WORD_WIDTH-1:0]};
    assign w_a_ext    = !w_is_w ? src_1_i :
                        (w_signed ? w_a_sx : {{c_PAD_W{1'b0}}, src_1_i[WORD_WIDTH-1:0]});
    assign w_b_ext    = !w_is_w ? src_2_i :
                        (w_signed ? w_b_sx : {{c_PAD_W{1'b0}}, src_2_i[WORD_WIDTH-1:0]});
    assign w_a_neg    = w_signed & w_a_ext[DATA_WIDTH-1];
    assign w_b_neg    = w_signed & w_b_ext[DATA_WIDTH-1];
    assign w_a_mag    = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_mag    = w_b_neg ? -w_b_ext : w_b_ext;
    assign w_min      = w_is_w ? {{(c_PAD_W + 1){1'b1}}, {(WORD_WIDTH - 1){1'b0}}}
                               : {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    assign w_div_zero = (w_b_ext == '0);
    assign w_overflow = w_signed && (w_a_ext == w_min) && (w_b_ext == '1);

    // One restoring step: shift in the next dividend bit, trial-subtract with a sign bit
    logic [DATA_WIDTH:0]   w_rem_shift;
    logic [DATA_WIDTH:0]   w_trial;
    logic                  w_q_bit;

    assign w_rem_shift = {r_rem, r_quot[DATA_WIDTH-1]};
    assign w_trial     = w_rem_shift - {1'b0, r_divisor};
    assign w_q_bit     = ~w_trial[DATA_WIDTH];

    logic [DATA_WIDTH-1:0] w_q_fix;
    logic [DATA_WIDTH-1:0] w_r_fix;
    logic [DATA_WIDTH-1:0] w_sel;
    logic [DATA_WIDTH-1:0] w_final;

    assign w_q_fix = r_neg_q ? -r_quot : r_quot;
    assign w_r_fix = r_neg_r ? -r_rem : r_rem;
    assign w_sel   = r_is_rem ? w_r_fix : w_q_fix;
    assign w_final = r_is_w ? {{c_PAD_W{w_sel[WORD_WIDTH-1]}}, w_sel[WORD_WIDTH-1:0]} : w_sel;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_result     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_is_w      <= w_is_w;
                        r_is_rem    <= w_is_rem;
                        r_neg_q     <= w_a_neg ^ w_b_neg;
                        r_neg_r     <= w_a_neg;
                        r_rem       <= '0;
                        r_divisor   <= w_b_mag;
                        r_quot      <= w_is_w ? {w_a_mag[WORD_WIDTH-1:0], {c_PAD_W{1'b0}}} : w_a_mag;
                        r_cnt       <= w_is_w ? c_CNT_W'(WORD_WIDTH) : c_CNT_W'(DATA_WIDTH);
                        if (!w_known) begin
                            r_state      <= S_DONE;
                            r_resp_valid <= 1'b1;
                            r_result     <= '0;
                        end else if (w_div_zero) begin
                            r_state      <= S_DONE;
                            r_resp_valid <= 1'b1;
                            r_result     <= w_is_rem ? (w_is_w ? w_a_sx : src_1_i) : '1;
                        end else if (w_overflow) begin
                            r_state      <= S_DONE;
                            r_resp_valid <= 1'b1;
                            r_result     <= w_is_rem ? '0 : w_a_ext;
                        end else begin
                            r_state      <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem  <= w_trial[DATA_WIDTH] ? w_rem_shift[DATA_WIDTH-1:0] : w_trial[DATA_WIDTH-1:0];
                    r_quot <= {r_quot[DATA_WIDTH-2:0], w_q_bit};
                    r_cnt  <= r_cnt - c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result     <= w_final;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_DONE;
                end
                default: begin
                    if (resp_ready_i) begin
                        r_state      <= S_IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_result     <= '0;
                    end
                end
            endcase
        end
    end

    assign req_ready_o  = r_req_ready;
    assign resp_valid_o = r_resp_valid;
    assign busy_o       = r_busy;
    assign div_result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Directed self-checking bench for div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    localparam logic [4:0] c_DIV   = 5'b10011;
    localparam logic [4:0] c_DIVU  = 5'b10100;
    localparam logic [4:0] c_REM   = 5'b10101;
    localparam logic [4:0] c_REMU  = 5'b10110;
    localparam logic [4:0] c_DIVW  = 5'b11000;
    localparam logic [4:0] c_DIVUW = 5'b11001;
    localparam logic [4:0] c_REMW  = 5'b11010;
    localparam logic [4:0] c_REMUW = 5'b11011;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [4:0]  div_control_i;
    logic [63:0] src_1_i;
    logic [63:0] src_2_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [63:0] div_result_o;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    div_unit dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .div_control_i (div_control_i),
        .src_1_i       (src_1_i),
        .src_2_i       (src_2_i),
        .resp_valid_o  (resp_valid_o),
        .resp_ready_i  (resp_ready_i),
        .div_result_o  (div_result_o),
        .busy_o        (busy_o)
    );

    // Issues one request and waits (bounded) for resp_valid; leaves the unit in DONE.
    task automatic run_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int lat, output bit rdy_low);
        @(negedge clk_i);
        div_control_i = op;
        src_1_i       = a;
        src_2_i       = b;
        req_valid_i   = 1'b1;
        @(posedge clk_i);
        lat = 1;
        @(negedge clk_i);
        req_valid_i   = 1'b0;
        div_control_i = 5'b00000;
        src_1_i       = {$urandom, $urandom};
        src_2_i       = {$urandom, $urandom};
        rdy_low       = 1'b1;
        while (!resp_valid_o && lat < 200) begin
            if (req_ready_o) rdy_low = 1'b0;
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
        end
        res = div_result_o;
    endtask

    task automatic release_resp();
        resp_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        resp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_checks++; if (req_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b expected 1", req_ready_o); end
        n_checks++; if (resp_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", resp_valid_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        n_checks++; if (div_result_o !== 64'h0) begin n_errors++; $display("FAIL reset_result: got %h expected 0", div_result_o); end
        rst_ni = 1'b1;
    endtask

    task automatic test_div64();
        logic [63:0] res; int lat; bit rl;
        run_op(c_DIV, 64'd100, 64'd7, res, lat, rl);
        n_checks++; if (res !== 64'd14) begin n_errors++; $display("FAIL div_100_7: got %h expected %h", res, 64'd14); end
        n_checks++; if (lat !== 66) begin n_errors++; $display("FAIL div_latency: got %0d expected 66", lat); end
        n_checks++; if (rl !== 1'b1) begin n_errors++; $display("FAIL div_ready_low: got %b expected 1", rl); end
        n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL div_busy_done: got %b expected 1", busy_o); end
        release_resp();
        n_checks++; if (resp_valid_o !== 1'b0 || div_result_o !== 64'h0 || req_ready_o !== 1'b1)
            begin n_errors++; $display("FAIL div_release: got valid=%b res=%h ready=%b expected 0 0 1", resp_valid_o, div_result_o, req_ready_o); end
        run_op(c_REM, 64'd100, 64'd7, res, lat, rl);
        n_checks++; if (res !== 64'd2) begin n_errors++; $display("FAIL rem_100_7: got %h expected %h", res, 64'd2); end
        n_checks++; if (lat !== 66) begin n_errors++; $display("FAIL rem_latency: got %0d expected 66", lat); end
        release_resp();
    endtask

    task automatic test_signed();
        logic [63:0] res; int lat; bit rl;
        run_op(c_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, res, lat, rl);
        n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_errors++; $display("FAIL div_m7_2: got %h expected fffffffffffffffd", res); end
        release_resp();
        run_op(c_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, res, lat, rl);
        n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_errors++; $display("FAIL rem_m7_2: got %h expected ffffffffffffffff", res); end
        release_resp();
        run_op(c_DIV, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, res, lat, rl);
        n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_errors++; $display("FAIL div_7_m2: got %h expected fffffffffffffffd", res); end
        release_resp();
        run_op(c_REM, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, res, lat, rl);
        n_checks++; if (res !== 64'd1) begin n_errors++; $display("FAIL rem_7_m2: got %h expected 1", res); end
        release_resp();
        run_op(c_REMU, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, res, lat, rl);
        n_checks++; if (res !== 64'd7) begin n_errors++; $display("FAIL remu_7_big: got %h expected 7", res); end
        release_resp();
        run_op(c_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, res, lat, rl);
        n_checks++; if (res !== 64'h0FFF_FFFF_FFFF_FFFF) begin n_errors++; $display("FAIL divu_max_16: got %h expected 0fffffffffffffff", res); end
        release_resp();
    endtask

    task automatic test_special();
        logic [63:0] res; int lat; bit rl;
        run_op(c_DIVU, 64'd5, 64'd0, res, lat, rl);
        n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_errors++; $display("FAIL divu_5_0: got %h expected ffffffffffffffff", res); end
        n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL divz_latency: got %0d expected 1", lat); end
        release_resp();
        run_op(c_REM, 64'd5, 64'd0, res, lat, rl);
        n_checks++; if (res !== 64'd5) begin n_errors++; $display("FAIL rem_5_0: got %h expected 5", res); end
        release_resp();
        run_op(c_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, lat, rl);
        n_checks++; if (res !== 64'h8000_0000_0000_0000) begin n_errors++; $display("FAIL div_ovf: got %h expected 8000000000000000", res); end
        n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL ovf_latency: got %0d expected 1", lat); end
        release_resp();
        run_op(c_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, lat, rl);
        n_checks++; if (res !== 64'h0) begin n_errors++; $display("FAIL rem_ovf: got %h expected 0", res); end
        release_resp();
        run_op(5'b00000, 64'd100, 64'd7, res, lat, rl);
        n_checks++; if (res !== 64'h0 || lat !== 1) begin n_errors++; $display("FAIL unknown_op: got %h lat %0d expected 0 lat 1", res, lat); end
        release_resp();
    endtask

    task automatic test_word();
        logic [63:0] res; int lat; bit rl;
        run_op(c_DIVW, 64'hDEAD_BEEF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, lat, rl);
        n_checks++; if (res !== 64'hFFFF_FFFF_8000_0000) begin n_errors++; $display("FAIL divw_ovf: got %h expected ffffffff80000000", res); end
        release_resp();
        run_op(c_DIVUW, 64'h1234_5678_FFFF_FFFE, 64'd2, res, lat, rl);
        n_checks++; if (res !== 64'h0000_0000_7FFF_FFFF) begin n_errors++; $display("FAIL divuw_big_2: got %h expected 000000007fffffff", res); end
        n_checks++; if (lat !== 34) begin n_errors++; $display("FAIL w_latency: got %0d expected 34", lat); end
        release_resp();
        run_op(c_REMW, 64'hAAAA_AAAA_FFFF_FFF9, 64'h5555_5555_0000_0002, res, lat, rl);
        n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_errors++; $display("FAIL remw_m7_2: got %h expected ffffffffffffffff", res); end
        release_resp();
        run_op(c_DIVW, 64'h0000_0001_FFFF_FFF9, 64'd2, res, lat, rl);
        n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_errors++; $display("FAIL divw_m7_2: got %h expected fffffffffffffffd", res); end
        release_resp();
        run_op(c_DIVUW, 64'h0000_0000_FFFF_FFFF, 64'hF000_0000_0000_0001, res, lat, rl);
        n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_errors++; $display("FAIL divuw_sext: got %h expected ffffffffffffffff", res); end
        release_resp();
        run_op(c_REMUW, 64'h0000_0000_8000_0001, 64'h1_0000_0000, res, lat, rl);
        n_checks++; if (res !== 64'hFFFF_FFFF_8000_0001) begin n_errors++; $display("FAIL remuw_div0: got %h expected ffffffff80000001", res); end
        release_resp();
    endtask

    task automatic test_back_to_back();
        logic [63:0] res; int lat; bit rl; bit stable;
        run_op(c_DIV, 64'd100, 64'd7, res, lat, rl);
        div_control_i = c_DIVU; src_1_i = 64'd5; src_2_i = 64'd0; req_valid_i = 1'b1;
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (div_result_o !== 64'd14 || resp_valid_o !== 1'b1 || req_ready_o !== 1'b0) stable = 1'b0;
        end
        n_checks++; if (stable !== 1'b1) begin n_errors++; $display("FAIL hold_stable: got %b expected 1", stable); end
        resp_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        n_checks++; if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin n_errors++; $display("FAIL release_no_accept: got valid=%b ready=%b expected 0 1", resp_valid_o, req_ready_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        n_checks++; if (resp_valid_o !== 1'b1 || div_result_o !== 64'hFFFF_FFFF_FFFF_FFFF)
            begin n_errors++; $display("FAIL next_accept: got valid=%b res=%h expected 1 ffffffffffffffff", resp_valid_o, div_result_o); end
        release_resp();
    endtask

    task automatic test_flush();
        logic [63:0] res; int lat; bit rl; bit saw;
        @(negedge clk_i);
        div_control_i = c_DIV; src_1_i = 64'd100; src_2_i = 64'd7; req_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (19) @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b0;
        n_checks++; if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin n_errors++; $display("FAIL flush_calc: got ready=%b busy=%b expected 1 0", req_ready_o, busy_o); end
        saw = 1'b0;
        repeat (70) begin @(negedge clk_i); if (resp_valid_o) saw = 1'b1; end
        n_checks++; if (saw !== 1'b0) begin n_errors++; $display("FAIL flush_no_resp: got %b expected 0", saw); end
        run_op(c_DIVU, 64'd5, 64'd0, res, lat, rl);
        flush_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b0;
        n_checks++; if (resp_valid_o !== 1'b0 || div_result_o !== 64'h0 || req_ready_o !== 1'b1)
            begin n_errors++; $display("FAIL flush_done: got valid=%b res=%h ready=%b expected 0 0 1", resp_valid_o, div_result_o, req_ready_o); end
        div_control_i = c_DIVU; src_1_i = 64'd5; src_2_i = 64'd0;
        req_valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0; flush_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0 || resp_valid_o !== 1'b0) begin n_errors++; $display("FAIL flush_priority: got busy=%b valid=%b expected 0 0", busy_o, resp_valid_o); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res; int lat; bit rl;
        @(negedge clk_i);
        div_control_i = c_DIV; src_1_i = 64'd100; src_2_i = 64'd7; req_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        n_checks++; if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || busy_o !== 1'b0 || div_result_o !== 64'h0)
            begin n_errors++; $display("FAIL reset_mid: got ready=%b valid=%b busy=%b res=%h expected 1 0 0 0", req_ready_o, resp_valid_o, busy_o, div_result_o); end
        rst_ni = 1'b1;
        run_op(c_DIVU, 64'd1000, 64'd10, res, lat, rl);
        n_checks++; if (res !== 64'd100) begin n_errors++; $display("FAIL after_reset: got %h expected %h", res, 64'd100); end
        release_resp();
    endtask

    initial begin
        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        req_valid_i   = 1'b0;
        resp_ready_i  = 1'b0;
        div_control_i = 5'b00000;
        src_1_i       = 64'h0;
        src_2_i       = 64'h0;
        test_reset();
        test_div64();
        test_signed();
        test_special();
        test_word();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
